// File: rtl/alu_ex_stage_pkg.sv
// rtl/alu_ex_stage_pkg.sv - shared ALU-op encodings and execute-stage occupancy states
package alu_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_XXX    = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/alu_ex_stage_alu.sv
// rtl/alu_ex_stage_alu.sv - combinational RV32I ALU
module alu
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Unlisted codes (including ALU_XXX) produce zero but still flow downstream.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_COPY_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - RV32I execute stage with registered two-slot skid output
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_rd,
  input  logic            in_we,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_rd,
  output logic            out_we
);

  occ_t            state;
  occ_t            state_nxt;
  logic            accept;
  logic            present;
  logic            ld_main_new;
  logic            ld_main_skid;
  logic            ld_skid;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] skid_result;
  logic [TAGW-1:0] skid_rd;
  logic            skid_we;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (in_a),
    .b      (in_b),
    .op     (in_aluop),
    .result (alu_result)
  );

  assign accept  = in_valid && in_ready;
  assign present = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
        OCC_ONE: begin
          if (accept && !present)      state_nxt = OCC_FULL;
          else if (!accept && present) state_nxt = OCC_EMPTY;
        end
        OCC_FULL:  if (present) state_nxt = OCC_ONE;
        default:   state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Both handshake outputs decode only the state register, so decode never sees downstream stalls.
  always_comb begin
    in_ready  = (state != OCC_FULL);
    out_valid = (state != OCC_EMPTY);
  end

  assign ld_main_new  = accept && !flush && ((state == OCC_EMPTY) || present);
  assign ld_skid      = accept && !flush && (state == OCC_ONE) && !present;
  assign ld_main_skid = !flush && (state == OCC_FULL) && present;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result  <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
    end else begin
      if (ld_main_new) begin
        out_result <= alu_result;
        out_rd     <= in_rd;
        out_we     <= in_we;
      end else if (ld_main_skid) begin
        out_result <= skid_result;
        out_rd     <= skid_rd;
        out_we     <= skid_we;
      end
      if (ld_skid) begin
        skid_result <= alu_result;
        skid_rd     <= in_rd;
        skid_we     <= in_we;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - scoreboard bench for alu_ex_stage
module tb_alu_ex_stage;
  import alu_ex_stage_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_aluop = 4'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  alu_ex_stage #(.XLEN(32), .TAGW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got rd %0d result 0x%08h expected none", out_rd, out_result);
      end else begin
        e = sb.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("out_we", {31'd0, out_we}, {31'd0, e.we});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we, input logic fl,
                       input logic ordy, input logic exp_rdy, input logic [31:0] exp_res);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_aluop  = op;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    in_we     = we;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy && !fl) sb.push_back(exp_t'{exp_res, rd, we});
    if (fl) begin
      #1;
      sb.delete();
    end
  endtask

  task automatic idle(input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic drain();
    idle(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_we", {31'd0, out_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming ALU vectors, one per cycle with downstream always ready
    issue(ALU_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    issue(ALU_SUB,    32'h0000_0000, 32'h0000_0001, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    issue(ALU_SRA,    32'h8000_0000, 32'h0000_0024, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'hF800_0000);
    issue(ALU_SRL,    32'h8000_0000, 32'h0000_0024, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0800_0000);
    issue(ALU_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0001);
    issue(ALU_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 5'd6,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
    issue(ALU_AND,    32'hF0F0_1234, 32'h0FF0_FF00, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00F0_1200);
    issue(ALU_OR,     32'hF000_0000, 32'h0000_000F, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 32'hF000_000F);
    issue(ALU_XOR,    32'hFFFF_0000, 32'h0F0F_0F0F, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'hF0F0_0F0F);
    issue(ALU_SLL,    32'h0000_0001, 32'h0000_003F, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    issue(ALU_COPY_B, 32'h0000_0001, 32'hDEAD_BEEF, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    issue(ALU_XXX,    32'h0000_0005, 32'h0000_0007, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
    issue(4'hC,       32'h0000_0005, 32'h0000_0007, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
    drain();

    // Backpressure: third op stalls until the first present out of FULL
    issue(ALU_ADD, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
    issue(ALU_ADD, 32'h20, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
    issue(ALU_ADD, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h30);
    chk("hold_out_rd", {27'd0, out_rd}, 32'd1);
    chk("hold_out_result", out_result, 32'h10);
    issue(ALU_ADD, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h30);
    issue(ALU_ADD, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30);
    drain();

    // Flush while FULL with a simultaneous request
    issue(ALU_ADD, 32'h40, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
    issue(ALU_ADD, 32'h50, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h50);
    issue(ALU_ADD, 32'h60, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h60);
    idle(1'b0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush drops a same-cycle accept but honours the same-cycle present
    issue(ALU_ADD, 32'h70, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h70);
    issue(ALU_ADD, 32'h80, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    idle(1'b1);
    chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
    idle(1'b1);

    // Asynchronous reset between edges while FULL
    issue(ALU_ADD, 32'h90, 32'h0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 32'h90);
    issue(ALU_ADD, 32'hA0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0);
    idle(1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("arst_out_we", {31'd0, out_we}, 32'd0);
    sb.delete();
    #1;
    rst = 1'b0;
    idle(1'b1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    issue(ALU_SUB, 32'h5, 32'h7, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute stage of the RV32I pipeline. Accepts a decoded operation (4-bit ALU op from the ALU decoder, two 32-bit operands, destination tag) from decode. Computes the ALU result and presents it, registered, to the memory/writeback stage over a valid/ready handshake. A two-entry skid buffer keeps `in_ready` a pure register output, so decode sees no combinational path from downstream stalls.

## Interface
- `XLEN`, 32, operand/result width
- `TAGW`, 5, destination register tag width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  decode presents an operation
- `in_ready`  out  1  stage can accept; registered
- `in_aluop`  in  4  ALU op, encodings per shared ALU-op header
- `in_a`, `in_b`  in  XLEN  operands (`in_b` is imm or rs2, already muxed)
- `in_rd`  in  TAGW  destination tag
- `in_we`  in  1  register write enable
- `flush`  in  1  kill all held operations (branch mispredict/trap)
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts
- `out_result`  out  XLEN  ALU result
- `out_rd`  out  TAGW  tag of presented result
- `out_we`  out  1  write enable of presented result

## Operation
- Accept on `in_valid && in_ready`; present on `out_valid && out_ready`.
- ALU evaluated combinationally on the input side; the result, `in_rd` and `in_we` are captured into a slot.
- Two slots:
  - MAIN drives the outputs.
  - SKID holds one overflow entry.
- Occupancy states:
  - EMPTY: MAIN invalid, SKID invalid.
  - ONE: MAIN valid, SKID invalid.
  - FULL: both valid.
- Transitions, with A = accept and P = present:
  - EMPTY+A → ONE.
  - ONE+A+P → ONE (MAIN reloaded).
  - ONE+A+!P → FULL (new entry to SKID).
  - ONE+!A+P → EMPTY.
  - FULL+P → ONE (SKID moves to MAIN).
  - FULL+!P → FULL.
- `in_ready` = !SKID valid. No accept occurs in FULL.
- Ordering strictly FIFO. SKID never bypasses MAIN.
- ALU ops (operands `a`, `b`, shift amount `b[4:0]`):
  - ADD a+b, SUB a−b, both modulo 2^XLEN.
  - AND, OR, XOR bitwise.
  - SLL logical left; SRL logical right; SRA arithmetic right.
  - SLT: signed a<b → 1 else 0, zero-extended.
  - SLTU: unsigned compare, same result form.
  - COPY_B passes `b`.
  - ALU_XXX or any unlisted code → result 0, operation still flows normally.
- `flush`:
  - Synchronously clears both valid bits next edge.
  - Dominates a same-cycle accept: the accepted operation is dropped.
  - A same-cycle present still completes: the downstream handshake is honoured.
- Data registers are not cleared by flush, only valids.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - `out_result`=0, `out_rd`=0, `out_we`=0.
  - SKID contents 0.
- Async assertion of `rst` clears state immediately regardless of `clk`.
- Latency: accept at edge N → `out_valid` high after edge N, result presented in cycle N+1.
- Throughput: 1 op/cycle while `out_ready` held high.
- `in_ready` drops the cycle after FULL is entered. It returns high the cycle after the first present out of FULL.
- `out_*` held stable while `out_valid && !out_ready`.
- Reset mid-operation: all in-flight ops lost, state EMPTY.

## Structure
- ALU op constants live in the shared ALU-op header, also used by the ALU decoder. No local redefinition.
- Opcode constants are not needed here.
- One sub-module: `alu`, purely combinational, inputs `XLEN` a/b and 4-bit op, output result. Reused by any later stage needing arithmetic.
- Slot/skid control stays inline in `alu_ex_stage`.

## Test plan
- Reset then ADD a=0x7FFFFFFF b=1, `out_ready`=1 → next cycle `out_valid`=1, `out_result`=0x80000000; SUB 0−1 → 0xFFFFFFFF.
- Shift/compare:
  - SRA 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
  - SRL same → 0x08000000.
  - SLT 0xFFFFFFFF<1 → 1; SLTU same → 0.
- Backpressure: `out_ready`=0, issue ops tagged rd 1,2,3 back-to-back → third not accepted, `in_ready`=0 after second. Then `out_ready`=1 → results emerge rd 1,2,3 in order, none duplicated or lost.
- Flush in FULL with simultaneous `in_valid` → next cycle `out_valid`=0, `in_ready`=1; the dropped op never appears.
- ALU_XXX op with a=5 b=7 → result 0, `out_we` passes through unchanged.
- Assert `rst` asynchronously between edges while FULL → outputs return to reset values before the next edge.
